// File: rtl/keypad_scanner_if.sv
// Keypad bus: matrix lines toward the Pmod KYPD plus the decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_down;
   logic       key_valid;
   logic [1:0] dbg_state;

   modport master (
      input  row,
      output col, key_code, key_down, key_valid, dbg_state
   );

   modport slave (
      output row,
      input  col, key_code, key_down, key_valid, dbg_state
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, whole-scan debounce, hex decode.
// Optional auto-repeat of key_valid when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 250
) (
   input  logic              clk,
   input  logic              rst,
   keypad_scanner_if.master  kp
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      COL0 = 2'd0,
      COL1 = 2'd1,
      COL2 = 2'd2,
      COL3 = 2'd3
   } col_state_t;

   col_state_t       r_state;
   col_state_t       w_state_next;
   logic [3:0]       w_col;
   logic [CNT_W-1:0] r_slot_cnt;
   logic             w_slot_last;
   logic             w_scan_end;
   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;
   logic [11:0]      r_snap_lo;
   logic [15:0]      w_snap_full;
   logic [15:0]      r_prev;
   logic [15:0]      r_stable;
   logic [DB_W-1:0]  r_stable_cnt;
   logic [DB_W-1:0]  w_cnt_next;
   logic             w_load;
   logic             w_fresh;
   logic             w_repeat;
   logic [3:0]       r_key_code;
   logic             r_key_valid;

   function automatic logic is_single(input logic [15:0] v);
      return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
   endfunction

   // Bit index is 4*col + row; only meaningful for a one-hot map.
   function automatic logic [3:0] legend_of(input logic [15:0] v);
      logic [3:0] idx;
      logic [3:0] code;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = i[3:0];
      end
      case (idx)
         4'd0:  code = 4'h1;  4'd1:  code = 4'h4;  4'd2:  code = 4'h7;  4'd3:  code = 4'h0;
         4'd4:  code = 4'h2;  4'd5:  code = 4'h5;  4'd6:  code = 4'h8;  4'd7:  code = 4'hF;
         4'd8:  code = 4'h3;  4'd9:  code = 4'h6;  4'd10: code = 4'h9;  4'd11: code = 4'hE;
         4'd12: code = 4'hA;  4'd13: code = 4'hB;  4'd14: code = 4'hC;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= kp.row;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_slot_last = (r_slot_cnt == SLOT_LAST);
   assign w_scan_end  = w_slot_last && (r_state == COL3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_cnt <= '0;
         r_state    <= COL0;
      end else begin
         r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + 1'b1;
         r_state    <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_col        = 4'b1110;
      case (r_state)
         COL0: begin
            w_col = 4'b1110;
            if (w_slot_last) w_state_next = COL1;
         end
         COL1: begin
            w_col = 4'b1101;
            if (w_slot_last) w_state_next = COL2;
         end
         COL2: begin
            w_col = 4'b1011;
            if (w_slot_last) w_state_next = COL3;
         end
         COL3: begin
            w_col = 4'b0111;
            if (w_slot_last) w_state_next = COL0;
         end
         default: w_state_next = COL0;
      endcase
   end

   // Column 3 is never stored: at scan end it is merged straight from the synchroniser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap_lo <= '0;
      end else if (w_slot_last) begin
         case (r_state)
            COL0:    r_snap_lo[3:0]  <= ~r_row_sync;
            COL1:    r_snap_lo[7:4]  <= ~r_row_sync;
            COL2:    r_snap_lo[11:8] <= ~r_row_sync;
            default: ;
         endcase
      end
   end

   assign w_snap_full = {~r_row_sync, r_snap_lo};
   assign w_cnt_next  = (w_snap_full != r_prev) ? DB_W'(1) :
                        (r_stable_cnt == DB_MAX) ? DB_MAX : r_stable_cnt + 1'b1;
   assign w_load      = w_scan_end && (w_cnt_next == DB_MAX);
   assign w_fresh     = w_load && is_single(w_snap_full) &&
                        (!is_single(r_stable) || (w_snap_full != r_stable));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev       <= '0;
         r_stable     <= '0;
         r_stable_cnt <= '0;
      end else if (w_scan_end) begin
         r_prev       <= w_snap_full;
         r_stable_cnt <= w_cnt_next;
         if (w_load) r_stable <= w_snap_full;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

   logic [REP_W-1:0] r_rep_cnt;
   logic [15:0]      w_stable_next;
   logic             w_held;

   assign w_stable_next = w_load ? w_snap_full : r_stable;
   assign w_held        = !w_fresh && is_single(w_stable_next);
   assign w_repeat      = w_scan_end && w_held && (r_rep_cnt == REP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rep_cnt <= '0;
      end else if (w_scan_end) begin
         if (!w_held || (r_rep_cnt == REP_LAST)) r_rep_cnt <= '0;
         else                                     r_rep_cnt <= r_rep_cnt + 1'b1;
      end
   end
`else
   assign w_repeat = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
      end else begin
         if (w_fresh) r_key_code <= legend_of(w_snap_full);
         r_key_valid <= w_fresh || w_repeat;
      end
   end

   assign kp.col       = w_col;
   assign kp.key_code  = r_key_code;
   assign kp.key_down  = is_single(r_stable);
   assign kp.key_valid = r_key_valid;
   assign kp.dbg_state = r_state;

endmodule
